// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit and its iterative multiply/divide sequencer.
package alu_ctrl_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;
    localparam logic [2:0] ALUOP_XOR   = 3'b110;
    localparam logic [2:0] ALUOP_LUI   = 3'b111;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    localparam logic [3:0] SIG_AND = 4'b0000;
    localparam logic [3:0] SIG_OR  = 4'b0001;
    localparam logic [3:0] SIG_ADD = 4'b0010;
    localparam logic [3:0] SIG_XOR = 4'b0011;
    localparam logic [3:0] SIG_SLL = 4'b0100;
    localparam logic [3:0] SIG_SUB = 4'b0110;
    localparam logic [3:0] SIG_SLT = 4'b0111;
    localparam logic [3:0] SIG_SRL = 4'b1000;
    localparam logic [3:0] SIG_SRA = 4'b1001;
    localparam logic [3:0] SIG_LUI = 4'b1010;
    localparam logic [3:0] SIG_NOR = 4'b1100;

    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider on operand magnitudes;
// signs are reapplied combinationally on the final iteration.
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d, div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [WIDTH-1:0]   acc_q, acc_d, x_q, x_d, y_q, y_d, rs_q, rs_d;

    logic               signed_op, a_neg, b_neg, div_ge;
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH-1:0]   acc_st, x_st;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // Single iteration: acc:x is the product / remainder:dividend pair.
    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = signed_op && a[WIDTH-1];
        b_neg     = signed_op && b[WIDTH-1];
        mul_sum   = {1'b0, acc_q} + (x_q[0] ? {1'b0, y_q} : '0);
        div_sh    = {acc_q, x_q[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, y_q};
        if (div_q) begin
            acc_st = div_ge ? WIDTH'(div_sh - {1'b0, y_q}) : div_sh[WIDTH-1:0];
            x_st   = {x_q[WIDTH-2:0], div_ge};
        end else begin
            acc_st = mul_sum[WIDTH:1];
            x_st   = {mul_sum[0], x_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        run_d  = run_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        rs_d   = rs_q;
        done   = 1'b0;
        if (start) begin
            run_d  = 1'b1;
            cnt_d  = CNT_W'(WIDTH - 1);
            div_d  = (op == MD_DIV) || (op == MD_DIVU);
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            dz_d   = div_d && (b == '0);
            acc_d  = '0;
            x_d    = a_neg ? -a : a;
            y_d    = b_neg ? -b : b;
            rs_d   = a;
        end else if (run_q) begin
            acc_d = acc_st;
            x_d   = x_st;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                run_d = 1'b0;
                done  = 1'b1;
            end
        end
    end

    // Final HI/LO, valid in the cycle that asserts done.
    always_comb begin
        prod     = {acc_st, x_st};
        prod_fix = neg_q ? -prod : prod;
        if (div_q) begin
            lo_next = dz_q ? '1 : (neg_q ? -x_st : x_st);
            hi_next = dz_q ? rs_q : (rneg_q ? -acc_st : acc_st);
        end else begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            rs_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            acc_q  <= acc_d;
            x_q    <= x_d;
            y_q    <= y_d;
            rs_q   <= rs_d;
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// ALU control decode plus the issue/stall sequencer that owns the HI/LO registers.
module alu_control_md
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [SIG_W-1:0] alu_signal,
    output logic             jr_signal,
    output logic             md_sel,
    output logic [WIDTH-1:0] md_result,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [3:0]       sig4;
    logic             md_req, rd_hi, issue, md_done;
    md_op_e           md_op;
    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q, hi_next, lo_next;

    always_comb begin
        sig4      = SIG_AND;
        jr_signal = 1'b0;
        md_sel    = 1'b0;
        md_req    = 1'b0;
        md_op     = MD_MULT;
        rd_hi     = 1'b0;
        case (alu_op)
            ALUOP_ADD:   sig4 = SIG_ADD;
            ALUOP_SUB:   sig4 = SIG_SUB;
            ALUOP_AND:   sig4 = SIG_AND;
            ALUOP_OR:    sig4 = SIG_OR;
            ALUOP_SLT:   sig4 = SIG_SLT;
            ALUOP_XOR:   sig4 = SIG_XOR;
            ALUOP_LUI:   sig4 = SIG_LUI;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:   sig4 = SIG_ADD;
                    FN_SUB:   sig4 = SIG_SUB;
                    FN_AND:   sig4 = SIG_AND;
                    FN_OR:    sig4 = SIG_OR;
                    FN_SLT:   sig4 = SIG_SLT;
                    FN_XOR:   sig4 = SIG_XOR;
                    FN_NOR:   sig4 = SIG_NOR;
                    FN_SLL:   sig4 = SIG_SLL;
                    FN_SRL:   sig4 = SIG_SRL;
                    FN_SRA:   sig4 = SIG_SRA;
                    FN_JR: begin
                        sig4      = SIG_ADD;
                        jr_signal = 1'b1;
                    end
                    FN_MULT:  md_req = 1'b1;
                    FN_MULTU: begin
                        md_req = 1'b1;
                        md_op  = MD_MULTU;
                    end
                    FN_DIV: begin
                        md_req = 1'b1;
                        md_op  = MD_DIV;
                    end
                    FN_DIVU: begin
                        md_req = 1'b1;
                        md_op  = MD_DIVU;
                    end
                    FN_MFHI: begin
                        md_sel = 1'b1;
                        rd_hi  = 1'b1;
                    end
                    FN_MFLO:  md_sel = 1'b1;
                    default:  sig4 = SIG_AND;
                endcase
            end
            default:     sig4 = SIG_AND;
        endcase
        alu_signal = SIG_W'(sig4);
        md_result  = md_sel ? (rd_hi ? hi_q : lo_q) : '0;
    end

    // DONE lets the held instruction retire once without re-issuing.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (md_req && !rst) begin
                    issue   = 1'b1;
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (md_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (md_done) begin
                hi_q <= hi_next;
                lo_q <= lo_next;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start   (issue),
        .op      (md_op),
        .a       (rs_val),
        .b       (rt_val),
        .done    (md_done),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

endmodule

// File: tb/tb_alu_control_md.sv
// Randomized bench comparing alu_control_md against an arithmetic reference model every cycle.
module tb_alu_control_md;
    localparam int unsigned W  = 32;
    localparam int unsigned W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [2:0]    alu_op;
    logic [5:0]    funct;
    logic [W-1:0]  rs_val, rt_val, md_result, hi, lo;
    logic [3:0]    alu_signal;
    logic          jr_signal, md_sel, stall;

    logic [2:0]    alu_op8;
    logic [5:0]    funct8;
    logic [W8-1:0] rs8, rt8, md_result8, hi8, lo8;
    logic [3:0]    alu_signal8;
    logic          jr8, md_sel8, stall8;

    alu_control_md #(.WIDTH(W), .SIG_W(4)) dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .alu_signal(alu_signal),
        .jr_signal(jr_signal), .md_sel(md_sel), .md_result(md_result),
        .stall(stall), .hi(hi), .lo(lo)
    );

    alu_control_md #(.WIDTH(W8), .SIG_W(4)) dut8 (
        .clk(clk), .rst(rst), .alu_op(alu_op8), .funct(funct8),
        .rs_val(rs8), .rt_val(rt8), .alu_signal(alu_signal8),
        .jr_signal(jr8), .md_sel(md_sel8), .md_result(md_result8),
        .stall(stall8), .hi(hi8), .lo(lo8)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Instruction table from the decode rules.
    function automatic void dec_model(input logic [2:0] op, input logic [5:0] f,
                                      output logic [3:0] sig, output logic jr,
                                      output logic msel, output logic is_md, output int kind);
        sig = 4'h0; jr = 1'b0; msel = 1'b0; is_md = 1'b0; kind = 0;
        case (op)
            3'd0: sig = 4'h2;
            3'd1: sig = 4'h6;
            3'd3: sig = 4'h0;
            3'd4: sig = 4'h1;
            3'd5: sig = 4'h7;
            3'd6: sig = 4'h3;
            3'd7: sig = 4'ha;
            default: begin
                case (f)
                    6'h20: sig = 4'h2;
                    6'h22: sig = 4'h6;
                    6'h24: sig = 4'h0;
                    6'h25: sig = 4'h1;
                    6'h2a: sig = 4'h7;
                    6'h26: sig = 4'h3;
                    6'h27: sig = 4'hc;
                    6'h00: sig = 4'h4;
                    6'h02: sig = 4'h8;
                    6'h03: sig = 4'h9;
                    6'h08: begin sig = 4'h2; jr = 1'b1; end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin is_md = 1'b1; kind = int'(f) - 24; end
                    6'h10, 6'h12: msel = 1'b1;
                    default: sig = 4'h0;
                endcase
            end
        endcase
    endfunction

    function automatic longint sx(input logic [63:0] v, input int w);
        longint t;
        t = longint'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    // kind: 0 mult, 1 multu, 2 div, 3 divu
    function automatic void md_model(input int w, input int kind, input logic [63:0] a,
                                     input logic [63:0] b, output logic [63:0] h,
                                     output logic [63:0] l);
        logic [63:0] m, ua, ub, up;
        longint sa, sb, sp;
        m  = (64'd1 << w) - 64'd1;
        ua = a & m;
        ub = b & m;
        sa = sx(ua, w);
        sb = sx(ub, w);
        case (kind)
            0: begin sp = sa * sb; h = 64'(sp >>> w) & m; l = 64'(sp) & m; end
            1: begin up = ua * ub; h = (up >> w) & m; l = up & m; end
            default: begin
                if (ub == 64'd0) begin
                    l = m; h = ua;
                end else if (kind == 2) begin
                    l = 64'(sa / sb) & m; h = 64'(sa % sb) & m;
                end else begin
                    l = ua / ub; h = ua % ub;
                end
            end
        endcase
    endfunction

    // Reference state: busy cycles left, done-cycle flag, architectural and pending HI/LO.
    logic [63:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_rem = 0;
    bit          m_done = 1'b0;

    always @(negedge clk) begin
        logic [3:0] s;
        logic j, ms, im, es;
        int k;
        logic [63:0] er;
        if (rst) begin
            m_rem = 0; m_done = 1'b0; m_hi = 0; m_lo = 0;
        end
        dec_model(alu_op, funct, s, j, ms, im, k);
        es = (m_rem > 0) || (!m_done && im && !rst);
        er = ms ? ((funct == 6'h10) ? m_hi : m_lo) : 64'd0;
        chk("alu_signal", 64'(alu_signal), 64'(s));
        chk("jr_signal", 64'(jr_signal), 64'(j));
        chk("md_sel", 64'(md_sel), 64'(ms));
        chk("md_result", 64'(md_result), er);
        chk("stall", 64'(stall), 64'(es));
        chk("hi", 64'(hi), m_hi);
        chk("lo", 64'(lo), m_lo);
        if (!rst) begin
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (im) begin
                md_model(W, k, 64'(rs_val), 64'(rt_val), p_hi, p_lo);
                m_rem = W;
            end
        end
    end

    // Entered just after a rising edge; md instructions are held issue..DONE.
    task automatic run_instr(input logic [2:0] op, input logic [5:0] f,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0] s;
        logic j, ms, im;
        int k, nst;
        dec_model(op, f, s, j, ms, im, k);
        alu_op = op; funct = f; rs_val = a; rt_val = b;
        if (im) begin
            nst = 0;
            for (int i = 0; i < W + 2; i++) begin
                @(negedge clk);
                if (stall) nst++;
                @(posedge clk); #1;
            end
            chk("stall_window", 64'(nst), 64'(W + 1));
        end else begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    localparam logic [5:0] FL [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h26,
                                       6'h27, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3f};

    initial begin
        int r, nst;
        rst = 1'b1; alu_op = 3'd0; funct = 6'd0; rs_val = '0; rt_val = '0;
        alu_op8 = 3'd0; funct8 = 6'd0; rs8 = '0; rt8 = '0;
        #2;
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_hi8", 64'(hi8), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int op = 0; op < 8; op++)
            if (op != 2) run_instr(3'(op), 6'($urandom), rnd_opnd(), rnd_opnd());
        for (int i = 0; i < 12; i++) begin
            run_instr(3'd2, FL[i], rnd_opnd(), rnd_opnd());
            if (FL[i] == 6'h08) begin
                chk("jr_flag", 64'(jr_signal), 64'h1);
                chk("jr_sig", 64'(alu_signal), 64'h2);
            end
            if (FL[i] == 6'h27) chk("nor_sig", 64'(alu_signal), 64'hc);
            if (FL[i] == 6'h3f) chk("unlisted_sig", 64'(alu_signal), 64'h0);
        end

        run_instr(3'd2, 6'h18, 32'hFFFF_FFFD, 32'd7);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        run_instr(3'd2, 6'h12, '0, '0);
        chk("mflo_res", 64'(md_result), 64'hFFFF_FFEB);
        chk("mflo_sel", 64'(md_sel), 64'h1);
        run_instr(3'd2, 6'h1b, 32'd100, 32'd7);
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);
        run_instr(3'd2, 6'h1a, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        run_instr(3'd2, 6'h1b, 32'h1234, 32'd0);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(hi), 64'h1234);
        run_instr(3'd2, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("minneg_lo", 64'(lo), 64'h8000_0000);
        chk("minneg_hi", 64'(hi), 64'h0);

        // Asynchronous reset ten cycles into a multiply.
        alu_op = 3'd2; funct = 6'h18; rs_val = 32'hFFFF_FFFD; rt_val = 32'd7;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_stall", 64'(stall), 64'h0);
        chk("midrst_hi", 64'(hi), 64'h0);
        chk("midrst_lo", 64'(lo), 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        run_instr(3'd2, 6'h19, 32'd2, 32'd3);
        chk("post_rst_lo", 64'(lo), 64'd6);
        chk("post_rst_hi", 64'(hi), 64'd0);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       run_instr(3'd2, 6'(6'h18 + $urandom_range(0, 3)), rnd_opnd(), rnd_opnd());
            else if (r < 6)  run_instr(3'd2, (r == 4) ? 6'h10 : 6'h12, rnd_opnd(), rnd_opnd());
            else if (r < 8)  run_instr(3'd2, FL[$urandom_range(0, 11)], rnd_opnd(), rnd_opnd());
            else             run_instr(3'($urandom_range(0, 7)), 6'($urandom), rnd_opnd(), rnd_opnd());
        end

        // Narrow instance: mult held exactly through DONE issues once.
        alu_op8 = 3'd2; funct8 = 6'h18; rs8 = 8'hFD; rt8 = 8'd7;
        nst = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (stall8) nst++;
            if (i == 9) chk("done_stall8", 64'(stall8), 64'h0);
            @(posedge clk); #1;
            if (i == 9) alu_op8 = 3'd0;
        end
        chk("stall_window8", 64'(nst), 64'd9);
        chk("mult8_hi", 64'(hi8), 64'hFF);
        chk("mult8_lo", 64'(lo8), 64'hEB);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
